// File: rtl/mix_columns_iter.sv
// mix_columns_iter: column-iterative AES/Rijndael MixColumns / InvMixColumns engine.
// A captured state of NB columns is processed CPC columns per cycle. The result is
// held on out_data under a valid/ready handshake until the downstream stage takes it.
module mix_columns_iter #(
  parameter int NB  = 4,
  parameter int CPC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*NB-1:0] in_data,
  input  logic            in_inv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_data,
  output logic            busy
);

  localparam int K  = NB / CPC;
  localparam int GW = (K > 1) ? $clog2(K) : 1;

  // Only Rijndael block sizes are meaningful, and groups must tile the state exactly
  generate
    if (!(NB == 4 || NB == 6 || NB == 8) || (NB % CPC) != 0) begin : g_bad_params
      $error("mix_columns_iter: NB must be 4, 6 or 8 and CPC must divide NB");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [GW-1:0]      g;
  logic               inv_q;
  logic [32*NB-1:0]   work_q;
  logic [32*NB-1:0]   result_q;
  logic [32*CPC-1:0]  grp_res;

  // Multiply by x in GF(2^8), reducing by 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the forward or inverse matrix, built from shared xtime chains
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      a[k]  = col[31-8*k -: 8];
      x2[k] = xtime(a[k]);
      x4[k] = xtime(x2[k]);
      x8[k] = xtime(x4[k]);
      m3[k] = x2[k] ^ a[k];
      m9[k] = x8[k] ^ a[k];
      mb[k] = x8[k] ^ x2[k] ^ a[k];
      md[k] = x8[k] ^ x4[k] ^ a[k];
      me[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    if (!inv) begin
      r = {x2[0] ^ m3[1] ^ a[2]  ^ a[3],
           a[0]  ^ x2[1] ^ m3[2] ^ a[3],
           a[0]  ^ a[1]  ^ x2[2] ^ m3[3],
           m3[0] ^ a[1]  ^ a[2]  ^ x2[3]};
    end else begin
      r = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
           m9[0] ^ me[1] ^ mb[2] ^ md[3],
           md[0] ^ m9[1] ^ me[2] ^ mb[3],
           mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end
    return r;
  endfunction

  // Columns of the current group, selected from the work register by the group counter
  always_comb begin
    grp_res = '0;
    for (int j = 0; j < CPC; j++) begin
      grp_res[32*CPC-1-32*j -: 32] =
        mix_col(work_q[32*NB-1-32*(int'(g)*CPC+j) -: 32], inv_q);
    end
  end

  // Control FSM with registered handshake flags; also owns the work and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      g         <= '0;
      inv_q     <= 1'b0;
      work_q    <= '0;
      result_q  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work_q   <= in_data;
            inv_q    <= in_inv;
            g        <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          for (int j = 0; j < CPC; j++) begin
            result_q[32*NB-1-32*(int'(g)*CPC+j) -: 32] <= grp_res[32*CPC-1-32*j -: 32];
          end
          if (g == GW'(K-1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            g <= g + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = result_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: scoreboard bench driving several engine configurations side by side.
// All instances share clock, reset, in_data and in_inv; each has its own handshake lines.
module tb_mix_columns_iter;

  localparam int NI = 6;

  // Configuration table: instance index -> (NB, CPC)
  function automatic int nb_of(input int i);
    case (i)
      0, 1, 2: return 4;
      3:       return 6;
      default: return 8;
    endcase
  endfunction

  function automatic int cpc_of(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 3;
      4: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int k_of(input int i);
    return nb_of(i) / cpc_of(i);
  endfunction

  logic           clk = 1'b0;
  logic           rst;
  logic [255:0]   in_data;
  logic           in_inv;
  logic [NI-1:0]  in_valid;
  logic [NI-1:0]  out_ready;
  logic [NI-1:0]  in_ready;
  logic [NI-1:0]  out_valid;
  logic [NI-1:0]  busy;
  logic [255:0]   out_data_a [NI];

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q [$];

  always #5 clk = ~clk;

  generate
    for (genvar i = 0; i < NI; i++) begin : g_dut
      localparam int NB_I  = nb_of(i);
      localparam int CPC_I = cpc_of(i);
      logic [32*NB_I-1:0] od;
      mix_columns_iter #(.NB(NB_I), .CPC(CPC_I)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[i]),
        .in_ready  (in_ready[i]),
        .in_data   (in_data[32*NB_I-1:0]),
        .in_inv    (in_inv),
        .out_valid (out_valid[i]),
        .out_ready (out_ready[i]),
        .out_data  (od),
        .busy      (busy[i])
      );
      assign out_data_a[i] = 256'(od);
    end
  endgenerate

  // Generic shift-and-add GF(2^8) multiply used by the reference model
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // Reference MixColumns over an nb-column state held in the low bits
  function automatic logic [255:0] mix_ref(input logic [255:0] d, input int nb, input bit inv);
    logic [7:0] fwd [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0] bwd [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [255:0] res = '0;
    logic [31:0] col;
    logic [7:0] a [4];
    logic [7:0] acc;
    for (int c = 0; c < nb; c++) begin
      col = d[32*nb-1-32*c -: 32];
      for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gf_mul(inv ? bwd[(k-r+4)%4] : fwd[(k-r+4)%4], a[k]);
        res[32*nb-1-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [255:0] rand_state(input int nb);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
    return d & ((256'(1) << (32*nb)) - 256'(1));
  endfunction

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one block into instance idx, scramble inputs after accept, check latency and
  // result, optionally hold off out_ready for `hold` cycles, then complete the handshake
  task automatic applyStimulus(input int idx, input logic [255:0] data, input bit inv,
                               input logic [255:0] exp, input int hold);
    int lat;
    logic [255:0] want;
    @(negedge clk);
    in_data = data;
    in_inv  = inv;
    in_valid[idx] = 1'b1;
    checkOutput("in_ready_idle", 256'(in_ready[idx]), 256'(1));
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    in_inv  = ~inv;
    in_data = rand_state(8);
    lat = 0;
    while (!out_valid[idx] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 256'(lat), 256'(k_of(idx)));
    want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    checkOutput("out_data", out_data_a[idx], want);
    for (int h = 0; h < hold; h++) begin
      in_valid[idx] = 1'b1;
      in_data = rand_state(8);
      @(posedge clk); #1;
      checkOutput("hold_data", out_data_a[idx], want);
      checkOutput("hold_valid", 256'(out_valid[idx]), 256'(1));
      checkOutput("hold_in_ready", 256'(in_ready[idx]), 256'(0));
    end
    in_valid[idx] = 1'b0;
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
    checkOutput("hs_out_valid", 256'(out_valid[idx]), 256'(0));
    checkOutput("hs_in_ready", 256'(in_ready[idx]), 256'(1));
    checkOutput("hs_busy", 256'(busy[idx]), 256'(0));
  endtask

  // Hard stop so a wedged handshake can never hang the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [255:0] d;
    logic [255:0] r;
    bit saw_valid;

    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    in_data = '0;
    in_inv = 1'b0;

    // Reset values, and no accept while reset is held
    repeat (2) @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    in_data = 256'h1234;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 256'(in_ready), 256'({NI{1'b1}}));
    checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
    checkOutput("rst_busy", 256'(busy), 256'(0));
    checkOutput("rst_out_data", out_data_a[0], 256'(0));
    in_valid[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_busy", 256'(busy[0]), 256'(0));

    $display("[TB] forward / inverse known vectors");
    applyStimulus(0, 256'h db135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                  256'h 8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0);
    applyStimulus(0, 256'h 8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
                  256'h db135345_f20a225c_01010101_c6c6c6c6, 0);

    $display("[TB] FIPS-197 round state, forward then inverse");
    applyStimulus(0, 256'h d4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
                  256'h 046681e5_e0cb199a_48f8d37a_2806264c, 0);
    applyStimulus(0, 256'h 046681e5_e0cb199a_48f8d37a_2806264c, 1'b1,
                  256'h d4bf5d30_e0b452ae_b84111f1_1e2798e5, 0);

    $display("[TB] back-pressure");
    applyStimulus(0, 256'h db135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                  256'h 8e4da1bc_9fdc589d_01010101_c6c6c6c6, 10);

    $display("[TB] parameter sweep");
    for (int i = 0; i < 5; i++) begin
      for (int n = 0; n < 3; n++) begin
        d = rand_state(nb_of(i));
        r = mix_ref(d, nb_of(i), 1'b0);
        applyStimulus(i, d, 1'b0, r, 0);
        applyStimulus(i, r, 1'b1, d, 0);
      end
    end

    $display("[TB] reset during RUN");
    @(negedge clk);
    in_data = rand_state(8);
    in_inv = 1'b0;
    in_valid[5] = 1'b1;
    @(posedge clk); #1;
    in_valid[5] = 1'b0;
    checkOutput("rr_busy", 256'(busy[5]), 256'(1));
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("rr_out_valid", 256'(out_valid[5]), 256'(0));
    checkOutput("rr_out_data", out_data_a[5], 256'(0));
    checkOutput("rr_in_ready", 256'(in_ready[5]), 256'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid[5]) saw_valid = 1'b1;
    end
    checkOutput("rr_no_pulse", 256'(saw_valid), 256'(0));
    d = rand_state(8);
    applyStimulus(5, d, 1'b0, mix_ref(d, 8, 1'b0), 0);
    applyStimulus(5, mix_ref(d, 8, 1'b0), 1'b1, d, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_columns_iter.md
# mix_columns_iter

Parametrised, column-iterative AES/Rijndael MixColumns engine that runs in forward or inverse mode, selected per block. It processes a state of NB 32-bit columns at CPC columns per cycle, trading area for latency. Valid/ready handshakes on both sides mean it can stall on a busy downstream stage. It sits in the round datapath between ShiftRows/InvShiftRows and AddRoundKey, and serves both the cipher and inverse-cipher paths.

## Interface
- NB, default 4: state columns; legal 4, 6, 8 (Rijndael block 128/192/256 bits).
- CPC, default 1: columns processed per cycle; must divide NB, otherwise elaboration fails.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  in_data/in_inv are valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  32*NB  state. Column c = bits [32*NB-1-32c -: 32]; row 0 is the MSB byte of each column.
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled at accept.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32*NB  result, same byte layout as in_data.
- busy  out  1  high in RUN or DONE.

## Operation
- Per column (a0..a3), GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11B):
  - Forward matrix rows: {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
  - Inverse matrix rows: {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
  - Output row r = XOR over k of M[r][k]·a_k.
- Multiplication is an xtime chain, combinational within one cycle. No lookup tables.
- Columns are independent. Column order in the output is preserved.
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the work register, latch in_inv, clear group counter g, go to RUN.
  - RUN: each cycle compute columns g*CPC .. g*CPC+CPC-1 and write them into the result register. g increments. When g == NB/CPC-1, go to DONE.
  - DONE: out_valid=1, and out_data holds the result. On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. Inputs are ignored there; in_valid may stay high.
- in_data and in_inv may change after the accepting edge without effect.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- out_data keeps its last value after the handshake until the next result is written.
- Counter g is ceil(log2(NB/CPC)) bits, minimum 1. It never wraps past NB/CPC-1.

## Timing
- Reset values while rst is high: state IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, g=0. No transfer is accepted while rst is high.
- Reset mid-RUN or mid-DONE: the block is discarded, with no partial output and no out_valid pulse.
- Let K = NB/CPC. Call the accept edge E0:
  - out_valid rises after edge E0+K.
  - Example: NB=4, CPC=1 gives out_valid 4 cycles after accept; CPC=4 gives 1 cycle.
- Output handshake on edge Ex: out_valid drops and in_ready rises after Ex. The next accept is at Ex+1 at the earliest.
- Back-to-back throughput is one block per K+2 cycles with out_ready held high.
- out_ready=1 before out_valid=1 has no effect.
- Mode is per block: the in_inv latched at accept governs all K groups.

## Test plan
- Forward, NB=4, CPC=1:
  - input column 0 = db135345, columns 1..3 = f20a225c, 01010101, c6c6c6c6, in_inv=0.
  - Expect out_data = 8e4da1bc 9fdc589d 01010101 c6c6c6c6.
  - Expect out_valid exactly 4 cycles after accept.
- Inverse round-trip:
  - input 8e4da1bc 9fdc589d 01010101 c6c6c6c6, in_inv=1.
  - Expect db135345 f20a225c 01010101 c6c6c6c6.
  - Also check the FIPS-197 column: d4bf5d30 forward gives 046681e5, and inverse returns it.
- Back-pressure:
  - hold out_ready=0 for 10 cycles after out_valid.
  - out_data is constant, in_ready=0, and a second in_valid is not accepted.
  - Release out_ready: handshake, then in_ready=1 on the next cycle.
- Mode per block:
  - block A forward, then block B inverse, with in_inv toggled during A's RUN.
  - A is forward-only and B is inverse-only.
- Parameter sweep, (NB,CPC) in {(4,1),(4,2),(4,4),(6,3),(8,2)}:
  - random states checked against a reference model.
  - Latency is exactly NB/CPC, and forward∘inverse equals identity.
- Reset in RUN:
  - assert rst for 1 cycle during group 2 of an NB=8, CPC=1 block.
  - out_valid=0, out_data=0, in_ready=1. The next block completes correctly.
